// File: rtl/mult_par_pkg.sv
// rtl/mult_par_pkg.sv - shared types, defaults and parity helper for mult_par
package mult_par_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MUL   = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT      = 16;
  localparam int PARITY_ODD_DEFAULT = 0;

  // Callers zero-extend their data; extra zeros never change the parity.
  function automatic logic parity_calc(input logic [127:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/mult_par_shift_add.sv
// rtl/mult_par_shift_add.sv - unsigned WIDTH x WIDTH iterative shift-add multiplier
module mult_par_shift_add
  import mult_par_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               running;

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // product is the accumulator after the current step, so it is final while done is high
  assign product = acc_next;
  assign done    = running && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mult_par.sv
// rtl/mult_par.sv - signed multiplier with operand parity check and req/ack handshake
module mult_par
  import mult_par_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int PARITY_ODD = PARITY_ODD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   arg_a,
  input  logic               arg_a_parity,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_b_parity,
  input  logic               req,
  output logic               ack,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               result_rdy,
  output logic               arg_parity_error,
  output logic               busy
);

  localparam logic ODD = (PARITY_ODD != 0);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               a_par_q;
  logic               b_par_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               negate;
  logic               parity_bad;
  logic               mul_done;
  logic [2*WIDTH-1:0] mag_product;
  logic [2*WIDTH-1:0] signed_product;
  logic               capture;
  logic               start_mul;
  logic               finish_err;
  logic               finish_mul;

  assign parity_bad = (a_par_q != parity_calc(128'(a_q), ODD)) ||
                      (b_par_q != parity_calc(128'(b_q), ODD));

  // Negating the most-negative value yields 2^(WIDTH-1), still exact as unsigned.
  assign a_mag          = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_mag          = b_q[WIDTH-1] ? -b_q : b_q;
  assign negate         = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign signed_product = negate ? -mag_product : mag_product;

  mult_par_shift_add #(
    .WIDTH(WIDTH)
  ) u_shift_add (
    .clk    (clk),
    .rst    (rst),
    .start  (start_mul),
    .a      (a_mag),
    .b      (b_mag),
    .done   (mul_done),
    .product(mag_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = CHECK;
      CHECK:   state_next = parity_bad ? IDLE : MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture    = 1'b0;
    start_mul  = 1'b0;
    finish_err = 1'b0;
    finish_mul = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE:    capture = req;
      CHECK: begin
        busy       = 1'b1;
        start_mul  = !parity_bad;
        finish_err = parity_bad;
      end
      MUL: begin
        busy       = 1'b1;
        finish_mul = mul_done;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q              <= '0;
      b_q              <= '0;
      a_par_q          <= 1'b0;
      b_par_q          <= 1'b0;
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= parity_calc('0, ODD);
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
    end else begin
      ack        <= capture;
      result_rdy <= finish_err || finish_mul;
      if (capture) begin
        a_q     <= arg_a;
        b_q     <= arg_b;
        a_par_q <= arg_a_parity;
        b_par_q <= arg_b_parity;
      end
      if (finish_err) begin
        result           <= '0;
        result_parity    <= parity_calc('0, ODD);
        arg_parity_error <= 1'b1;
      end else if (finish_mul) begin
        result           <= signed_product;
        result_parity    <= parity_calc(128'(signed_product), ODD);
        arg_parity_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_par.sv
// tb/tb_mult_par.sv - scoreboard bench for mult_par (16-bit even and 8-bit odd instances)
module tb_mult_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        rst16, req16, pa16, pb16;
  logic [15:0] a16, b16;
  logic        ack16, rp16, rdy16, err16, busy16;
  logic [31:0] res16;

  logic        rst8, req8, pa8, pb8;
  logic [7:0]  a8, b8;
  logic        ack8, rp8, rdy8, err8, busy8;
  logic [15:0] res8;

  mult_par #(.WIDTH(16), .PARITY_ODD(0)) dut16 (
    .clk(clk), .rst(rst16), .arg_a(a16), .arg_a_parity(pa16), .arg_b(b16),
    .arg_b_parity(pb16), .req(req16), .ack(ack16), .result(res16),
    .result_parity(rp16), .result_rdy(rdy16), .arg_parity_error(err16), .busy(busy16)
  );

  mult_par #(.WIDTH(8), .PARITY_ODD(1)) dut8 (
    .clk(clk), .rst(rst8), .arg_a(a8), .arg_a_parity(pa8), .arg_b(b8),
    .arg_b_parity(pb8), .req(req8), .ack(ack8), .result(res8),
    .result_parity(rp8), .result_rdy(rdy8), .arg_parity_error(err8), .busy(busy8)
  );

  typedef struct {
    longint res;
    bit     rp;
    bit     err;
    int     ack_cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;
  logic ack16_prev = 1'b0;
  logic ack8_prev  = 1'b0;

  function automatic longint sext(longint v, int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic bit par(longint v, int w, bit odd);
    longint m = (longint'(1) <<< w) - 1;
    return bit'(($countones(v & m) % 2) == 1) ^ odd;
  endfunction

  function automatic exp_t model(longint a, longint b, bit pa, bit pb, int w, bit odd, int ack_cyc);
    exp_t   e;
    longint m2 = (longint'(1) <<< (2 * w)) - 1;
    e.ack_cyc = ack_cyc;
    if (pa != par(a, w, odd) || pb != par(b, w, odd)) begin
      e.res = 0;
      e.err = 1'b1;
    end else begin
      e.res = (sext(a, w) * sext(b, w)) & m2;
      e.err = 1'b0;
    end
    e.rp = par(e.res, 2 * w, odd);
    return e;
  endfunction

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdy16) begin
      if (q16.size() == 0) begin
        check("rdy16_unexpected", 1, 0);
      end else begin
        e16 = q16.pop_front();
        check("res16", longint'(res16), e16.res);
        check("rpar16", longint'(rp16), longint'(e16.rp));
        check("err16", longint'(err16), longint'(e16.err));
        check("lat16", longint'(cyc - e16.ack_cyc), e16.err ? 1 : 17);
      end
    end
    if (ack16) check("ack16_pulse", longint'(ack16_prev), 0);
    ack16_prev = ack16;
  end

  always @(negedge clk) begin
    if (rdy8) begin
      if (q8.size() == 0) begin
        check("rdy8_unexpected", 1, 0);
      end else begin
        e8 = q8.pop_front();
        check("res8", longint'(res8), e8.res);
        check("rpar8", longint'(rp8), longint'(e8.rp));
        check("err8", longint'(err8), longint'(e8.err));
        check("lat8", longint'(cyc - e8.ack_cyc), e8.err ? 1 : 9);
      end
    end
    if (ack8) check("ack8_pulse", longint'(ack8_prev), 0);
    ack8_prev = ack8;
  end

  task automatic wait_sig(bit wide, bit want_ack, int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_ack ? (wide ? ack16 : ack8) : (wide ? rdy16 : rdy8)) && n < limit);
  endtask

  // BFM: drive operands, raise req, drop it after ack, then wait for result_rdy
  task automatic send(bit wide, longint a, longint b, bit flip_a, bit flip_b);
    int  w   = wide ? 16 : 8;
    bit  odd = wide ? 1'b0 : 1'b1;
    bit  pa  = par(a, w, odd) ^ flip_a;
    bit  pb  = par(b, w, odd) ^ flip_b;
    bit  got;
    if (wide) begin
      a16 = a[15:0]; b16 = b[15:0]; pa16 = pa; pb16 = pb; req16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; pa8 = pa; pb8 = pb; req8 = 1'b1;
    end
    wait_sig(wide, 1'b1, 40);
    got = wide ? ack16 : ack8;
    check(wide ? "ack16_seen" : "ack8_seen", longint'(got), 1);
    if (wide) req16 = 1'b0; else req8 = 1'b0;
    if (!got) return;
    if (wide) q16.push_back(model(a, b, pa, pb, w, odd, cyc));
    else      q8.push_back(model(a, b, pa, pb, w, odd, cyc));
    wait_sig(wide, 1'b0, 40);
    check(wide ? "rdy16_seen" : "rdy8_seen", longint'(wide ? rdy16 : rdy8), 1);
  endtask

  function automatic longint pick(int w);
    longint lim = longint'(1) <<< (w - 1);
    case ($urandom_range(0, 5))
      0:       return -lim;
      1:       return lim - 1;
      2:       return 0;
      3:       return -1;
      default: return longint'($urandom_range(0, (1 << w) - 1)) - lim;
    endcase
  endfunction

  int c1, c2;

  initial begin
    rst16 = 1'b1; req16 = 1'b0; a16 = '0; b16 = '0; pa16 = 1'b0; pb16 = 1'b0;
    rst8  = 1'b1; req8  = 1'b0; a8  = '0; b8  = '0; pa8  = 1'b0; pb8  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst16_ack", longint'(ack16), 0);
    check("rst16_res", longint'(res16), 0);
    check("rst16_rpar", longint'(rp16), 0);
    check("rst16_rdy", longint'(rdy16), 0);
    check("rst16_err", longint'(err16), 0);
    check("rst16_busy", longint'(busy16), 0);
    check("rst8_rpar", longint'(rp8), 1);
    check("rst8_res", longint'(res8), 0);
    rst16 = 1'b0;
    rst8  = 1'b0;
    @(negedge clk);

    send(1'b1, 3, -5, 1'b0, 1'b0);
    send(1'b1, -32768, -32768, 1'b0, 1'b0);
    send(1'b1, 1, 7, 1'b1, 1'b0);
    send(1'b1, 0, -32768, 1'b0, 1'b0);

    // req held high across two back-to-back transactions
    a16 = 16'd2; b16 = 16'd3; pa16 = par(2, 16, 0); pb16 = par(3, 16, 0); req16 = 1'b1;
    wait_sig(1'b1, 1'b1, 40);
    c1 = cyc;
    check("held_ack1", longint'(ack16), 1);
    q16.push_back(model(2, 3, par(2, 16, 0), par(3, 16, 0), 16, 0, cyc));
    a16 = 16'hFFFC; b16 = 16'd6; pa16 = par(-4, 16, 0); pb16 = par(6, 16, 0);
    wait_sig(1'b1, 1'b1, 40);
    c2 = cyc;
    check("held_ack2", longint'(ack16), 1);
    q16.push_back(model(-4, 6, par(-4, 16, 0), par(6, 16, 0), 16, 0, cyc));
    req16 = 1'b0;
    check("held_spacing", longint'(c2 - c1), 18);
    repeat (20) @(negedge clk);

    // reset in the middle of MUL discards the operation
    a16 = 16'd100; b16 = 16'd200; pa16 = par(100, 16, 0); pb16 = par(200, 16, 0); req16 = 1'b1;
    wait_sig(1'b1, 1'b1, 40);
    req16 = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_mid_mul", longint'(busy16), 1);
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    check("mrst_ack", longint'(ack16), 0);
    check("mrst_res", longint'(res16), 0);
    check("mrst_rpar", longint'(rp16), 0);
    check("mrst_rdy", longint'(rdy16), 0);
    check("mrst_err", longint'(err16), 0);
    check("mrst_busy", longint'(busy16), 0);
    repeat (25) @(negedge clk);
    send(1'b1, 100, 200, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      send(1'b1, pick(16), pick(16), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    send(1'b0, 127, -128, 1'b0, 1'b0);
    send(1'b0, -128, -128, 1'b0, 1'b0);
    send(1'b0, 5, 9, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      send(1'b0, pick(8), pick(8), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    repeat (5) @(negedge clk);
    check("q16_drained", longint'(q16.size()), 0);
    check("q8_drained", longint'(q8.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
